// File: rtl/axi_bridge_pkg.sv
// Shared constants, state encodings and helpers for the AXI-lite to AXI4 bridge.
package axi_bridge_pkg;

   localparam logic [1:0] BURST_INCR       = 2'b01;
   localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;
   localparam logic [1:0] RESP_OKAY        = 2'b00;
   localparam logic [1:0] RESP_SLVERR      = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP, W_DONE} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_e;

   // AxSIZE encodes bytes-per-beat as log2, so a full-width beat is log2(strobe count).
   function automatic logic [2:0] axsize_from_strb(input int strb_width);
      return 3'($clog2(strb_width));
   endfunction

endpackage

// File: rtl/axil2axi_bridge_if.sv
// AXI-lite and AXI4 bus bundles used on the two sides of the bridge.
interface axil_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic                  awvalid, awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  wvalid, wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  bvalid, bready;
   logic [1:0]            bresp;
   logic                  arvalid, arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  rvalid, rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

interface axi4_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 6
);
   logic                  awvalid, awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic [3:0]            awcache;
   logic [ID_WIDTH-1:0]   awid;
   logic                  wvalid, wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  bvalid, bready;
   logic [1:0]            bresp;
   logic [ID_WIDTH-1:0]   bid;
   logic                  arvalid, arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic [3:0]            arcache;
   logic [ID_WIDTH-1:0]   arid;
   logic                  rvalid, rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic [ID_WIDTH-1:0]   rid;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst, awcache, awid,
             wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, arsize, arburst, arcache, arid, rready,
      input  awready, wready, bvalid, bresp, bid,
             arready, rvalid, rdata, rresp, rlast, rid
   );
   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst, awcache, awid,
             wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, arsize, arburst, arcache, arid, rready,
      output awready, wready, bvalid, bresp, bid,
             arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/axil_hold_reg.sv
// Single-entry capture register: accepts one payload, then blocks until cleared.
module axil_hold_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             clear_i,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear_i) full_d = 1'b0;
      if (valid_i && !full_q) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign ready_o = !full_q;
   assign full_o  = full_q;
   assign data_o  = data_q;

endmodule

// File: rtl/axil2axi_bridge.sv
// AXI-lite responder to AXI4 initiator bridge: each AXI-lite access becomes one
// single-beat AXI4 burst; independent read and write engines, one in flight each.
module axil2axi_bridge
   import axi_bridge_pkg::*;
#(
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  DATA_WIDTH = 64,
   parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
   parameter int                  ID_WIDTH   = 6,
   parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
   input  logic   clk,
   input  logic   rst,
   axil_if.slave  s_axil,
   axi4_if.master m_axi
);

   localparam int W_PAYLOAD_W = DATA_WIDTH + STRB_WIDTH;

   logic                   aw_full, w_full, ar_full;
   logic                   w_clear, r_clear;
   logic [ADDR_WIDTH-1:0]  aw_addr, ar_addr;
   logic [W_PAYLOAD_W-1:0] w_payload;
   logic                   aw_fire, w_fire, ar_fire;

   axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
      .clk(clk), .rst(rst),
      .valid_i(s_axil.awvalid), .ready_o(s_axil.awready), .data_i(s_axil.awaddr),
      .clear_i(w_clear), .full_o(aw_full), .data_o(aw_addr)
   );

   axil_hold_reg #(.WIDTH(W_PAYLOAD_W)) u_w_hold (
      .clk(clk), .rst(rst),
      .valid_i(s_axil.wvalid), .ready_o(s_axil.wready),
      .data_i({s_axil.wstrb, s_axil.wdata}),
      .clear_i(w_clear), .full_o(w_full), .data_o(w_payload)
   );

   axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
      .clk(clk), .rst(rst),
      .valid_i(s_axil.arvalid), .ready_o(s_axil.arready), .data_i(s_axil.araddr),
      .clear_i(r_clear), .full_o(ar_full), .data_o(ar_addr)
   );

   assign aw_fire = s_axil.awvalid && !aw_full;
   assign w_fire  = s_axil.wvalid  && !w_full;
   assign ar_fire = s_axil.arvalid && !ar_full;

   // ---------------- write engine ----------------
   w_state_e   w_state_q, w_state_d;
   logic       m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
   logic       m_bready_q, m_bready_d, s_bvalid_q, s_bvalid_d;
   logic [1:0] s_bresp_q, s_bresp_d;

   always_comb begin
      w_state_d   = w_state_q;
      m_awvalid_d = m_awvalid_q;
      m_wvalid_d  = m_wvalid_q;
      m_bready_d  = m_bready_q;
      s_bvalid_d  = s_bvalid_q;
      s_bresp_d   = s_bresp_q;
      w_clear     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            // Count a capture happening this cycle so the AXI4 side starts one cycle later.
            if ((aw_full || aw_fire) && (w_full || w_fire)) begin
               w_state_d   = W_ISSUE;
               m_awvalid_d = 1'b1;
               m_wvalid_d  = 1'b1;
            end
         end
         W_ISSUE: begin
            if (m_axi.awready) m_awvalid_d = 1'b0;
            if (m_axi.wready)  m_wvalid_d  = 1'b0;
            if (!m_awvalid_d && !m_wvalid_d) begin
               w_state_d  = W_RESP;
               m_bready_d = 1'b1;
            end
         end
         W_RESP: begin
            if (m_axi.bvalid) begin
               s_bresp_d  = (m_axi.bid != AXI_ID) ? RESP_SLVERR : m_axi.bresp;
               m_bready_d = 1'b0;
               s_bvalid_d = 1'b1;
               w_state_d  = W_DONE;
            end
         end
         W_DONE: begin
            if (s_axil.bready) begin
               s_bvalid_d = 1'b0;
               w_clear    = 1'b1;
               w_state_d  = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q   <= W_IDLE;
         m_awvalid_q <= 1'b0;
         m_wvalid_q  <= 1'b0;
         m_bready_q  <= 1'b0;
         s_bvalid_q  <= 1'b0;
         s_bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q   <= w_state_d;
         m_awvalid_q <= m_awvalid_d;
         m_wvalid_q  <= m_wvalid_d;
         m_bready_q  <= m_bready_d;
         s_bvalid_q  <= s_bvalid_d;
         s_bresp_q   <= s_bresp_d;
      end
   end

   // ---------------- read engine ----------------
   r_state_e              r_state_q, r_state_d;
   logic                  m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
   logic                  s_rvalid_q, s_rvalid_d, beat_seen_q, beat_seen_d;
   logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
   logic [1:0]            s_rresp_q, s_rresp_d;

   always_comb begin
      r_state_d   = r_state_q;
      m_arvalid_d = m_arvalid_q;
      m_rready_d  = m_rready_q;
      s_rvalid_d  = s_rvalid_q;
      s_rdata_d   = s_rdata_q;
      s_rresp_d   = s_rresp_q;
      beat_seen_d = beat_seen_q;
      r_clear     = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (ar_fire) begin
               r_state_d   = R_ADDR;
               m_arvalid_d = 1'b1;
            end
         end
         R_ADDR: begin
            if (m_axi.arready) begin
               m_arvalid_d = 1'b0;
               m_rready_d  = 1'b1;
               r_state_d   = R_DATA;
            end
         end
         R_DATA: begin
            // Only the first beat is returned; a multi-beat reply is drained and flagged.
            if (m_axi.rvalid) begin
               if (!beat_seen_q) begin
                  s_rdata_d   = m_axi.rdata;
                  s_rresp_d   = (m_axi.rid != AXI_ID || !m_axi.rlast) ? RESP_SLVERR : m_axi.rresp;
                  beat_seen_d = 1'b1;
               end
               if (m_axi.rlast) begin
                  m_rready_d  = 1'b0;
                  s_rvalid_d  = 1'b1;
                  beat_seen_d = 1'b0;
                  r_state_d   = R_DONE;
               end
            end
         end
         R_DONE: begin
            if (s_axil.rready) begin
               s_rvalid_d = 1'b0;
               r_clear    = 1'b1;
               r_state_d  = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q   <= R_IDLE;
         m_arvalid_q <= 1'b0;
         m_rready_q  <= 1'b0;
         s_rvalid_q  <= 1'b0;
         s_rdata_q   <= '0;
         s_rresp_q   <= RESP_OKAY;
         beat_seen_q <= 1'b0;
      end else begin
         r_state_q   <= r_state_d;
         m_arvalid_q <= m_arvalid_d;
         m_rready_q  <= m_rready_d;
         s_rvalid_q  <= s_rvalid_d;
         s_rdata_q   <= s_rdata_d;
         s_rresp_q   <= s_rresp_d;
         beat_seen_q <= beat_seen_d;
      end
   end

   // ---------------- output mapping ----------------
   assign s_axil.bvalid = s_bvalid_q;
   assign s_axil.bresp  = s_bresp_q;
   assign s_axil.rvalid = s_rvalid_q;
   assign s_axil.rdata  = s_rdata_q;
   assign s_axil.rresp  = s_rresp_q;

   assign m_axi.awvalid = m_awvalid_q;
   assign m_axi.awaddr  = aw_addr;
   assign m_axi.awlen   = 8'd0;
   assign m_axi.awsize  = axsize_from_strb(STRB_WIDTH);
   assign m_axi.awburst = BURST_INCR;
   assign m_axi.awcache = CACHE_MODIFIABLE;
   assign m_axi.awid    = AXI_ID;
   assign m_axi.wvalid  = m_wvalid_q;
   assign m_axi.wdata   = w_payload[DATA_WIDTH-1:0];
   assign m_axi.wstrb   = w_payload[DATA_WIDTH +: STRB_WIDTH];
   assign m_axi.wlast   = 1'b1;
   assign m_axi.bready  = m_bready_q;

   assign m_axi.arvalid = m_arvalid_q;
   assign m_axi.araddr  = ar_addr;
   assign m_axi.arlen   = 8'd0;
   assign m_axi.arsize  = axsize_from_strb(STRB_WIDTH);
   assign m_axi.arburst = BURST_INCR;
   assign m_axi.arcache = CACHE_MODIFIABLE;
   assign m_axi.arid    = AXI_ID;
   assign m_axi.rready  = m_rready_q;

   // Protection attributes are accepted but have no AXI4-side meaning here.
   logic unused_prot;
   assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

endmodule

// File: tb/tb_axil2axi_bridge.sv
// Randomized bench for axil2axi_bridge with a transaction-level expectation model.
module tb_axil2axi_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axil ();
   axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(6)) axi ();

   axil2axi_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .STRB_WIDTH(8), .ID_WIDTH(6), .AXI_ID(6'd0)
   ) dut (
      .clk(clk), .rst(rst), .s_axil(axil), .m_axi(axi)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // order: 0 = AW and W together, 1 = AW first, 2 = W first (gap cycles apart)
   task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input int order, input int gap, input int da, input int dw, input int db,
                           input logic [5:0] bid, input logic [1:0] bresp, input int bp);
      bit aw_done, w_done, hs_aw, hs_w;
      int c, aw_st, w_st;
      int unsigned t0;
      logic [1:0] exp_resp;
      aw_st = (order == 2) ? gap : 0;
      w_st  = (order == 1) ? gap : 0;
      aw_done = 0; w_done = 0; c = 0; t0 = cyc;
      axil.awaddr = addr; axil.wdata = data; axil.wstrb = strb;
      while (!(aw_done && w_done) && c < 40) begin
         axil.awvalid = !aw_done && c >= aw_st;
         axil.wvalid  = !w_done && c >= w_st;
         hs_aw = axil.awvalid && axil.awready;
         hs_w  = axil.wvalid && axil.wready;
         if (hs_aw || hs_w) t0 = cyc;
         tick();
         aw_done |= hs_aw; w_done |= hs_w; c++;
      end
      axil.awvalid = 0; axil.wvalid = 0;
      check_eq("up_accept", {aw_done, w_done}, 2'b11);
      check_eq("issue_aw", {axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awcache, axi.awid},
               {1'b1, addr, 8'd0, 3'd3, 2'b01, 4'b0010, 6'd0});
      check_eq("issue_w", {axi.wvalid, axi.wdata, axi.wstrb, axi.wlast}, {1'b1, data, strb, 1'b1});
      aw_done = 0; w_done = 0; c = 0;
      while (!(aw_done && w_done) && c < 40) begin
         axi.awready = !aw_done && c >= da;
         axi.wready  = !w_done && c >= dw;
         hs_aw = axi.awvalid && axi.awready;
         hs_w  = axi.wvalid && axi.wready;
         tick();
         aw_done |= hs_aw; w_done |= hs_w; c++;
         if (hs_aw && !w_done) check_eq("aw_drop", {axi.awvalid, axi.wvalid}, 2'b01);
         if (hs_w && !aw_done) check_eq("w_drop", {axi.awvalid, axi.wvalid}, 2'b10);
      end
      axi.awready = 0; axi.wready = 0;
      check_eq("dn_accept", {aw_done, w_done}, 2'b11);
      check_eq("b_ready", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
      repeat (db) tick();
      axi.bvalid = 1; axi.bid = bid; axi.bresp = bresp;
      tick();
      axi.bvalid = 0;
      exp_resp = (bid != 6'd0) ? 2'b10 : bresp;
      check_eq("wr_resp", {axil.bvalid, axil.bresp, axi.bready}, {1'b1, exp_resp, 1'b0});
      check_eq("wr_latency", cyc - t0, 3 + ((da > dw) ? da : dw) + db);
      repeat (bp) begin axil.bready = 0; tick(); end
      if (bp > 0)
         check_eq("wr_hold", {axil.bvalid, axil.bresp, axil.awready, axil.wready}, {1'b1, exp_resp, 2'b00});
      axil.bready = 1;
      tick();
      axil.bready = 0;
      check_eq("wr_release", {axil.bvalid, axil.awready, axil.wready}, 3'b011);
   endtask

   task automatic do_read(input logic [31:0] addr, input int da, input int nbeats, input int max_gap,
                          input logic [5:0] rid, input logic [1:0] resp0, input logic [63:0] data0,
                          input int bp);
      int c, g, lat;
      int unsigned t0;
      logic [1:0] exp_resp;
      axil.arvalid = 1; axil.araddr = addr; c = 0;
      while (!axil.arready && c < 20) begin tick(); c++; end
      check_eq("ar_ready", axil.arready, 1'b1);
      t0 = cyc;
      tick();
      axil.arvalid = 0; axil.araddr = $urandom;
      check_eq("issue_ar", {axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arcache, axi.arid},
               {1'b1, addr, 8'd0, 3'd3, 2'b01, 4'b0010, 6'd0});
      repeat (da) tick();
      axi.arready = 1;
      tick();
      axi.arready = 0;
      check_eq("r_ready", {axi.arvalid, axi.rready}, 2'b01);
      lat = 3 + da;
      for (int b = 0; b < nbeats; b++) begin
         g = $urandom_range(0, max_gap);
         repeat (g) tick();
         lat += g + ((b > 0) ? 1 : 0);
         axi.rvalid = 1;
         axi.rdata  = (b == 0) ? data0 : {$urandom, $urandom};
         axi.rresp  = (b == 0) ? resp0 : 2'($urandom);
         axi.rlast  = (b == nbeats - 1);
         axi.rid    = rid;
         tick();
         axi.rvalid = 0; axi.rlast = 0;
      end
      exp_resp = (rid != 6'd0 || nbeats != 1) ? 2'b10 : resp0;
      check_eq("rd_resp", {axil.rvalid, axil.rdata, axil.rresp}, {1'b1, data0, exp_resp});
      check_eq("rd_latency", cyc - t0, lat);
      repeat (bp) begin axil.rready = 0; tick(); end
      if (bp > 0)
         check_eq("rd_hold", {axil.rvalid, axil.rdata, axil.rresp, axil.arready}, {1'b1, data0, exp_resp, 1'b0});
      axil.rready = 1;
      tick();
      axil.rready = 0;
      check_eq("rd_release", {axil.rvalid, axil.arready, axi.rready}, 3'b010);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [5:0] bid;
      axil.awvalid = 0; axil.awaddr = '0; axil.awprot = '0;
      axil.wvalid = 0; axil.wdata = '0; axil.wstrb = '0; axil.bready = 0;
      axil.arvalid = 0; axil.araddr = '0; axil.arprot = '0; axil.rready = 0;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0; axi.bid = '0;
      axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0; axi.rid = '0;

      repeat (3) tick();
      rst = 0;
      tick();
      check_eq("reset_ctrl", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid,
                              axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 10'b1110000000);
      check_eq("reset_data", {axil.rdata, axil.rresp, axil.bresp, axi.awaddr, axi.araddr}, 100'd0);

      do_read(32'h8000_0010, 0, 1, 0, 6'd0, 2'b00, 64'hDEAD_BEEF_0123_4567, 0);
      do_write(32'h100, 64'h11, 8'h01, 2, 4, 0, 0, 0, 6'd0, 2'b00, 0);
      do_write(32'h200, 64'hA5A5_0000_FFFF_1234, 8'hF0, 0, 0, 0, 3, 1, 6'd0, 2'b00, 2);
      do_read(32'h40, 0, 1, 0, 6'd5, 2'b00, 64'h0123_4567_89AB_CDEF, 0);
      do_read(32'h48, 1, 2, 0, 6'd0, 2'b00, 64'hCAFE_F00D_0000_0001, 0);
      do_read(32'h50, 0, 1, 1, 6'd0, 2'b01, 64'h5555_AAAA_5555_AAAA, 10);

      // reset while the write is waiting on the AXI4 address/data handshakes
      axil.awvalid = 1; axil.awaddr = 32'h300; axil.wvalid = 1; axil.wdata = 64'h77; axil.wstrb = 8'hFF;
      tick();
      axil.awvalid = 0; axil.wvalid = 0;
      check_eq("pre_reset_issue", {axi.awvalid, axi.wvalid}, 2'b11);
      rst = 1;
      tick();
      rst = 0;
      check_eq("mid_reset", {axi.awvalid, axi.wvalid, axil.awready, axil.wready, axil.arready,
                             axil.bvalid, axi.bready}, 7'b0011100);
      do_write(32'h304, 64'h0BAD_F00D_1234_5678, 8'h3C, 1, 2, 2, 1, 0, 6'd0, 2'b00, 1);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            bid = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            do_write($urandom, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), bid, 2'($urandom), $urandom_range(0, 4));
         end else begin
            bid = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            do_read($urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1,
                    $urandom_range(0, 2), bid, 2'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 10));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
